dram_cmd_responder: RTL and testbench

Device-side responder for the DRAM command stream produced by the controller's PRE/ACT/RDWR sequencer. It models per-bank row state and enforces tRP, tRCD, CL and burst spacing. It returns data-valid bursts after CAS latency and flags protocol violations. It sits opposite the controller in simulation and checks every issued command cycle by cycle.

---
 rtl/dram_cmd_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_dram_cmd_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder: device-side DRAM command responder with per-bank
// row FSMs, tRCD/tRP countdowns, a CL delay line and burst generation.
// Ports: clk, rst (sync, active-high); cmd_valid/op/bank/row/col in;
// bank_open, data_valid/we/bank/col, err/err_code out.
// Build option: DRAM_RESP_CHECK_EN builds legality checks and err output;
// without it every command is applied and err/err_code are tied to 0.
module dram_cmd_responder #(
  parameter int NUM_BANKS = 16,
  parameter int ROW_W     = 16,
  parameter int COL_W     = 10,
  parameter int T_RP      = 24,
  parameter int T_RCD     = 24,
  parameter int T_CL      = 24,
  parameter int T_BURST   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  input  logic [ROW_W-1:0]             cmd_row,
  input  logic [COL_W-1:0]             cmd_col,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         data_valid,
  output logic                         data_we,
  output logic [$clog2(NUM_BANKS)-1:0] data_bank,
  output logic [COL_W-1:0]             data_col,
  output logic                         err,
  output logic [2:0]                   err_code
);

  localparam int BW   = $clog2(NUM_BANKS);
  localparam int TMAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BCW  = (T_BURST > 1) ? $clog2(T_BURST) : 1;
  localparam int DLN  = T_CL - 1;

  typedef enum logic [1:0] {
    S_CLOSED,
    S_ACTIVATING,
    S_OPEN,
    S_PRECHARGING
  } bank_st_e;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [BW-1:0]    bank;
    logic [COL_W-1:0] col;
  } cas_t;

  bank_st_e         r_st     [NUM_BANKS];
  bank_st_e         w_st_nx  [NUM_BANKS];
  logic [CW-1:0]    r_cnt    [NUM_BANKS];
  logic [CW-1:0]    w_cnt_nx [NUM_BANKS];
  logic [ROW_W-1:0] r_row    [NUM_BANKS];

  logic w_act;
  logic w_pre;
  logic w_cas;
  logic w_ok;

  assign w_act = cmd_valid && (cmd_op == 2'b00);
  assign w_pre = cmd_valid && (cmd_op == 2'b01);
  assign w_cas = cmd_valid && cmd_op[1];

  // Counters load T-1 and the state flips on the edge that takes the
  // counter to zero, so the new state is visible exactly T cycles later.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_st_nx[b]  = r_st[b];
      w_cnt_nx[b] = r_cnt[b];
      unique case (r_st[b])
        S_ACTIVATING: begin
          if (r_cnt[b] <= CW'(1)) begin
            w_st_nx[b]  = S_OPEN;
            w_cnt_nx[b] = '0;
          end else begin
            w_cnt_nx[b] = r_cnt[b] - CW'(1);
          end
        end
        S_PRECHARGING: begin
          if (r_cnt[b] <= CW'(1)) begin
            w_st_nx[b]  = S_CLOSED;
            w_cnt_nx[b] = '0;
          end else begin
            w_cnt_nx[b] = r_cnt[b] - CW'(1);
          end
        end
        default: ;
      endcase
      if (w_ok && (cmd_bank == BW'(b))) begin
        if (w_act) begin
          w_st_nx[b]  = S_ACTIVATING;
          w_cnt_nx[b] = CW'(T_RCD - 1);
        end else if (w_pre &&
                     (r_st[b] == S_OPEN ||
                      r_st[b] == S_ACTIVATING)) begin
          w_st_nx[b]  = S_PRECHARGING;
          w_cnt_nx[b] = CW'(T_RP - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst) begin
        r_st[b]  <= S_CLOSED;
        r_cnt[b] <= '0;
      end else begin
        r_st[b]  <= w_st_nx[b];
        r_cnt[b] <= w_cnt_nx[b];
      end
    end
  end

  always_comb begin
    bank_open = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      bank_open[b] = (r_st[b] == S_OPEN);
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst)
        r_row[b] <= '0;
      else if (w_act && w_ok && (cmd_bank == BW'(b)))
        r_row[b] <= cmd_row;
    end
  end

  // The row is held for the controller's benefit only; fold it so the
  // storage is not considered dead.
  logic w_unused_row;
  always_comb begin
    w_unused_row = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++)
      w_unused_row = w_unused_row ^ (^r_row[b]);
  end

  // CL delay line: T_CL-1 stages plus the burst register give CL cycles.
  cas_t r_dl [DLN];
  cas_t w_cas_in;
  cas_t w_dl_out;

  assign w_cas_in = {w_cas && w_ok, cmd_op[0], cmd_bank, cmd_col};
  assign w_dl_out = r_dl[DLN-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLN; i++)
        r_dl[i] <= '0;
    end else begin
      r_dl[0] <= w_cas_in;
      for (int i = 1; i < DLN; i++)
        r_dl[i] <= r_dl[i-1];
    end
  end

  logic             r_dv;
  logic             r_dwe;
  logic [BW-1:0]    r_dbank;
  logic [COL_W-1:0] r_dcol;
  logic [BCW-1:0]   r_bcnt;

  // A new burst arriving takes priority so bursts can run back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv    <= 1'b0;
      r_dwe   <= 1'b0;
      r_dbank <= '0;
      r_dcol  <= '0;
      r_bcnt  <= '0;
    end else if (w_dl_out.v) begin
      r_dv    <= 1'b1;
      r_dwe   <= w_dl_out.we;
      r_dbank <= w_dl_out.bank;
      r_dcol  <= w_dl_out.col;
      r_bcnt  <= BCW'(T_BURST - 1);
    end else if (r_bcnt != '0) begin
      r_bcnt  <= r_bcnt - BCW'(1);
    end else begin
      r_dv    <= 1'b0;
      r_dwe   <= 1'b0;
      r_dbank <= '0;
      r_dcol  <= '0;
    end
  end

  assign data_valid = r_dv;
  assign data_we    = r_dwe;
  assign data_bank  = r_dbank;
  assign data_col   = r_dcol;

`ifdef DRAM_RESP_CHECK_EN
  localparam int GW = $clog2(T_BURST + 1);

  bank_st_e      w_tgt;
  logic [2:0]    w_code;
  logic [GW-1:0] r_gap;
  logic          r_err;
  logic [2:0]    r_err_code;

  assign w_tgt = r_st[cmd_bank];

  // r_gap == 0 means no column command since reset.
  always_comb begin
    w_code = 3'd0;
    unique case (1'b1)
      w_act: begin
        if (w_tgt == S_OPEN || w_tgt == S_ACTIVATING)
          w_code = 3'd1;
        else if (w_tgt == S_PRECHARGING)
          w_code = 3'd2;
      end
      w_cas: begin
        if (w_tgt == S_CLOSED || w_tgt == S_PRECHARGING)
          w_code = 3'd3;
        else if (w_tgt == S_ACTIVATING)
          w_code = 3'd4;
        else if (r_gap != '0 && r_gap < GW'(T_BURST))
          w_code = 3'd5;
      end
      w_pre: begin
        if (w_tgt == S_ACTIVATING)
          w_code = 3'd6;
      end
      default: ;
    endcase
  end

  assign w_ok = (w_code == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap      <= '0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
    end else begin
      if (w_cas && w_ok)
        r_gap <= GW'(1);
      else if (r_gap != '0 && r_gap < GW'(T_BURST))
        r_gap <= r_gap + GW'(1);
      r_err      <= (w_code != 3'd0);
      r_err_code <= w_code;
    end
  end

  assign err      = r_err;
  assign err_code = r_err_code;
`else
  assign w_ok     = 1'b1;
  assign err      = 1'b0;
  assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb_dram_cmd_responder: random + directed stimulus, timestamp-based
// bank model and queue scoreboard for dram_cmd_responder.
module tb_dram_cmd_responder;

  localparam int NB      = 16;
  localparam int BW      = 4;
  localparam int COL_W   = 10;
  localparam int T_RP    = 24;
  localparam int T_RCD   = 24;
  localparam int T_CL    = 24;
  localparam int T_BURST = 4;

`ifdef DRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int OP_ACT = 0;
  localparam int OP_PRE = 1;
  localparam int OP_RD  = 2;
  localparam int OP_WR  = 3;

  localparam int ST_CLOSED = 0;
  localparam int ST_ACTV   = 1;
  localparam int ST_OPEN   = 2;
  localparam int ST_PCH    = 3;

  localparam int K_NONE = 0;
  localparam int K_ACT  = 1;
  localparam int K_PRE  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [BW-1:0]     cmd_bank;
  logic [15:0]       cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic [NB-1:0]     bank_open;
  logic              data_valid;
  logic              data_we;
  logic [BW-1:0]     data_bank;
  logic [COL_W-1:0]  data_col;
  logic              err;
  logic [2:0]        err_code;

  dram_cmd_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .bank_open  (bank_open),
    .data_valid (data_valid),
    .data_we    (data_we),
    .data_bank  (data_bank),
    .data_col   (data_col),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic we;
    int   bank;
    int   col;
  } beat_t;

  typedef struct {
    int c;
    int code;
  } err_t;

  beat_t dq [$];
  err_t  eq [$];

  int last_t [NB];
  int last_k [NB];
  int prev_t [NB];
  int prev_k [NB];
  int last_cas = -1000;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic void record(int b, int c, int k);
    prev_t[b] = last_t[b];
    prev_k[b] = last_k[b];
    last_t[b] = c;
    last_k[b] = k;
  endfunction

  // Bank state at cycle c from the last command applied before c.
  function automatic int bstate(int b, int c);
    int t;
    int k;
    if (last_t[b] < c) begin
      t = last_t[b];
      k = last_k[b];
    end else begin
      t = prev_t[b];
      k = prev_k[b];
    end
    if (k == K_ACT)
      return (c >= t + T_RCD) ? ST_OPEN : ST_ACTV;
    if (k == K_PRE)
      return (c >= t + T_RP) ? ST_CLOSED : ST_PCH;
    return ST_CLOSED;
  endfunction

  function automatic int pick_open(int b0);
    for (int i = 0; i < NB; i++) begin
      int b = (b0 + i) % NB;
      if (bstate(b, cyc) == ST_OPEN)
        return b;
    end
    return b0;
  endfunction

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int op, input int b,
                       input int row, input int col);
    int c;
    int st;
    int code;
    c    = cyc;
    st   = bstate(b, c);
    code = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_bank  = BW'(b);
    cmd_row   = 16'(row);
    cmd_col   = COL_W'(col);
    if (CHK) begin
      if (op == OP_ACT) begin
        if (st == ST_OPEN || st == ST_ACTV) code = 1;
        else if (st == ST_PCH) code = 2;
      end else if (op >= OP_RD) begin
        if (st == ST_CLOSED || st == ST_PCH) code = 3;
        else if (st == ST_ACTV) code = 4;
        else if (c - last_cas < T_BURST) code = 5;
      end else begin
        if (st == ST_ACTV) code = 6;
      end
    end
    if (code != 0) begin
      eq.push_back('{c: c + 1, code: code});
    end else if (op == OP_ACT) begin
      record(b, c, K_ACT);
    end else if (op == OP_PRE) begin
      if (st == ST_OPEN || st == ST_ACTV)
        record(b, c, K_PRE);
    end else begin
      last_cas = c;
      for (int k = 0; k < T_BURST; k++)
        dq.push_back('{c: c + T_CL + k, we: (op == OP_WR),
                       bank: b, col: col});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // The command presented alongside reset must be ignored.
  task automatic do_reset();
    int c;
    c = cyc;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_bank  = BW'($urandom_range(0, NB - 1));
    for (int b = 0; b < NB; b++)
      record(b, c, K_NONE);
    last_cas = -1000;
    while (dq.size() > 0 && dq[$].c > c)
      void'(dq.pop_back());
    while (eq.size() > 0 && eq[$].c > c)
      void'(eq.pop_back());
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
  endtask

  logic [NB-1:0] m_open;
  beat_t         m_bt;
  err_t          m_er;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int b = 0; b < NB; b++)
        m_open[b] = (bstate(b, cyc) == ST_OPEN);
      chk("bank_open", bank_open, m_open);
      if (data_valid === 1'b1) begin
        if (dq.size() == 0) begin
          chk("data_valid", data_valid, 1'b0);
        end else begin
          m_bt = dq.pop_front();
          chk("beat_cycle", cyc, m_bt.c);
          chk("data_we", data_we, m_bt.we);
          chk("data_bank", data_bank, m_bt.bank);
          chk("data_col", data_col, m_bt.col);
        end
      end else if (dq.size() > 0 && dq[0].c <= cyc) begin
        chk("data_valid", data_valid, 1'b1);
        void'(dq.pop_front());
      end
      if (err === 1'b1) begin
        if (eq.size() == 0) begin
          chk("err", err, 1'b0);
        end else begin
          m_er = eq.pop_front();
          chk("err_cycle", cyc, m_er.c);
          chk("err_code", err_code, m_er.code);
        end
      end else if (eq.size() > 0 && eq[0].c <= cyc) begin
        chk("err", err, 1'b1);
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int b;
    for (int i = 0; i < NB; i++) begin
      last_t[i] = -1000;
      last_k[i] = K_NONE;
      prev_t[i] = -1000;
      prev_k[i] = K_NONE;
    end
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_bank  = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    issue(OP_ACT, 3, 16'h12, 0);
    idle(T_RCD - 1);
    issue(OP_RD, 3, 0, 5);
    idle(T_CL + T_BURST + 2);
    do_reset();

    issue(OP_ACT, 0, 16'h40, 0);
    idle(9);
    issue(OP_RD, 0, 0, 7);
    idle(T_CL + T_BURST + 2);
    do_reset();

    issue(OP_ACT, 1, 16'h77, 0);
    idle(T_RCD + 1);
    issue(OP_PRE, 1, 0, 0);
    idle(19);
    issue(OP_ACT, 1, 16'h78, 0);
    idle(3);
    issue(OP_ACT, 1, 16'h79, 0);
    idle(T_RCD + 2);
    do_reset();

    issue(OP_ACT, 0, 16'h1, 0);
    issue(OP_ACT, 1, 16'h2, 0);
    idle(T_RCD);
    issue(OP_RD, 0, 0, 11);
`ifdef DRAM_RESP_CHECK_EN
    idle(1);
    issue(OP_WR, 1, 0, 12);
    idle(1);
`else
    idle(3);
`endif
    issue(OP_WR, 1, 0, 13);
    idle(T_CL + T_BURST + 4);

    issue(OP_ACT, 2, 16'hAA, 0);
    idle(T_RCD + 2);
    issue(OP_ACT, 2, 16'hBB, 0);
    idle(T_RCD + 2);
    do_reset();

    issue(OP_ACT, 5, 16'h5, 0);
    idle(T_RCD - 1);
    issue(OP_RD, 5, 0, 99);
    idle(T_CL + 1);
    do_reset();
    idle(2);
    issue(OP_ACT, 5, 16'h6, 0);
    idle(T_RCD + 2);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      b = $urandom_range(0, NB - 1);
      if (r < 1) begin
        do_reset();
      end else if (r < 35) begin
        idle(1);
      end else if (r < 55) begin
        issue(OP_ACT, b, $urandom_range(0, 65535), 0);
      end else if (r < 70) begin
        issue(OP_PRE, b, 0, 0);
      end else begin
        if (CHK && r < 95)
          b = pick_open(b);
        if (cyc - last_cas >= T_BURST)
          issue(r[0] ? OP_WR : OP_RD, b, 0,
                $urandom_range(0, (1 << COL_W) - 1));
        else
          idle(1);
      end
    end

    idle(T_CL + T_BURST + 4);
    chk("beats_left", dq.size(), 0);
    chk("errs_left", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
